// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: load/store funct3 codes, data-memory FSM encoding,
// console address bit and the store lane decoder.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  localparam int unsigned CONSOLE_ADDR_BIT = 31;

  // Returns {illegal, byte_enable[3:0]}; illegal covers bad funct3 and misalignment.
  function automatic logic [4:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane);
    logic [4:0] r;
    r = 5'b1_0000;
    case (f3)
      F3_B:    r = {1'b0, 4'b0001 << lane};
      F3_H:    r = lane[0] ? 5'b1_0000 : {1'b0, (lane[1] ? 4'b1100 : 4'b0011)};
      F3_W:    r = (lane == 2'b00) ? 5'b0_1111 : 5'b1_0000;
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_load_ext.sv
// Load lane selection and sign/zero extension for RV32I loads; shared with the
// core writeback path. Illegal funct3 or misaligned lanes give data 0 and illegal_o=1.
module rv32i_load_ext
  import rv32i_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        illegal_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (lane_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_B:  data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU: data_o = {24'd0, byte_v};
      F3_H: begin
        if (lane_i[0]) illegal_o = 1'b1;
        else           data_o = {{16{half_v[15]}}, half_v};
      end
      F3_HU: begin
        if (lane_i[0]) illegal_o = 1'b1;
        else           data_o = {16'd0, half_v};
      end
      F3_W: begin
        if (lane_i != 2'b00) illegal_o = 1'b1;
        else                 data_o = word_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem.sv
// rv32i data-memory responder: one request per handshake, WAIT_STATES extra
// cycles, one-cycle response. Define RV32I_DMEM_CONSOLE_EN to map addr[31] to a console.
module rv32i_dmem
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned WAIT_STATES   = 0,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  logic idle, enter_resp;
  assign idle      = (state_q == DMEM_IDLE);
  assign req_ready = idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reset) begin
      state_d = DMEM_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DMEM_IDLE: if (req_valid) state_d = (WAIT_STATES > 0) ? DMEM_WAIT : DMEM_RESP;
        DMEM_WAIT: begin
          if (cnt_q == 4'(WAIT_STATES - 1)) begin
            state_d = DMEM_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = DMEM_IDLE;
      endcase
    end
  end

  assign enter_resp = (state_d == DMEM_RESP);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // operation is taken straight from the request inputs while in IDLE.
  logic                  op_we;
  logic [2:0]            op_f3;
  logic [ADDR_WIDTH+1:0] op_addr;
  logic [31:0]           op_wdata;
  assign op_we    = idle ? req_we                    : we_q;
  assign op_f3    = idle ? req_funct3                : f3_q;
  assign op_addr  = idle ? req_addr[ADDR_WIDTH+1:0]  : addr_q;
  assign op_wdata = idle ? req_wdata                 : wdata_q;

  logic [ADDR_WIDTH-1:0] op_idx;
  logic [1:0]            op_lane;
  logic [31:0]           rd_word;
  assign op_idx  = op_addr[ADDR_WIDTH+1:2];
  assign op_lane = op_addr[1:0];
  assign rd_word = mem[op_idx];

  logic [31:0] ld_data;
  logic        ld_illegal;

  rv32i_load_ext u_load_ext (
    .word_i    (rd_word),
    .lane_i    (op_lane),
    .funct3_i  (op_f3),
    .data_o    (ld_data),
    .illegal_o (ld_illegal)
  );

  logic        st_illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  assign {st_illegal, st_be} = store_lanes(op_f3, op_lane);

  always_comb begin
    case (op_f3)
      F3_B:    st_wdata = {4{op_wdata[7:0]}};
      F3_H:    st_wdata = {2{op_wdata[15:0]}};
      default: st_wdata = op_wdata;
    endcase
  end

`ifdef RV32I_DMEM_CONSOLE_EN
  logic con_q, op_con;
  assign op_con = idle ? req_addr[CONSOLE_ADDR_BIT] : con_q;
`endif

  logic        mem_we;
  logic        con_we;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;

  always_comb begin
    mem_we      = 1'b0;
    con_we      = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (op_we) begin
      rsp_err_d = st_illegal;
      mem_we    = !st_illegal;
    end else begin
      rsp_err_d   = ld_illegal;
      rsp_rdata_d = ld_data;
    end
`ifdef RV32I_DMEM_CONSOLE_EN
    if (op_con) begin
      mem_we      = 1'b0;
      rsp_rdata_d = '0;
      if (op_we) begin
        con_we    = (op_f3 == F3_B);
        rsp_err_d = (op_f3 != F3_B);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp;
      rsp_rdata_q <= enter_resp ? rsp_rdata_d : '0;
      rsp_err_q   <= enter_resp ? rsp_err_d : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && idle && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[ADDR_WIDTH+1:0];
      wdata_q <= req_wdata;
`ifdef RV32I_DMEM_CONSOLE_EN
      con_q   <= req_addr[CONSOLE_ADDR_BIT];
`endif
    end
  end

  // enter_resp is already false under reset, so a reset before RESP drops the store.
  always_ff @(posedge clk) begin
    if (enter_resp && mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) mem[op_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

`ifdef RV32I_DMEM_CONSOLE_EN
  always_ff @(posedge clk) begin
    if (enter_resp && con_we) $write("%c", op_wdata[7:0]);
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
